sum_of_squares_fx: RTL and testbench

//  Computes S = x^2 + y^2 + z^2 for a signed fixed-point 3-vector, the operand of SquareRoot.

---
 rtl/sum_of_squares_fx.sv | 112 +++++++++++
 tb/tb_sum_of_squares_fx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_of_squares_fx.sv
// sum_of_squares_fx: S = x^2 + y^2 + z^2 for a signed fixed-point 3-vector.
// One shared multiplier is stepped over the three components (one per cycle).
// The scaled result is clamped to the unsigned OUT_W-bit output range.
// Valid/ready handshake on both sides; one vector in flight at a time.
module sum_of_squares_fx #(
  parameter int IN_W     = 12,
  parameter int IN_FRAC  = 4,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  vec_x,
  input  logic [IN_W-1:0]  vec_y,
  input  logic [IN_W-1:0]  vec_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] sq_sum,
  output logic             sq_sat
);

  // Two guard bits cover the sum of three squares, so the accumulator never wraps.
  localparam int ACC_W = 2*IN_W + 2;
  // Products carry 2*IN_FRAC fraction bits; drop down to OUT_FRAC (truncate).
  localparam int SHIFT = 2*IN_FRAC - OUT_FRAC;
  localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACC, SAT, HOLD} state_t;

  state_t                   state;
  logic signed [IN_W-1:0]   op_x, op_y, op_z;
  logic signed [IN_W-1:0]   op;
  logic signed [2*IN_W-1:0] prod;
  logic [2*IN_W-1:0]        prod_u;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         scaled;
  logic                     sat_hit;
  logic [1:0]               idx;

  // Pick the component feeding the shared multiplier this cycle.
  always_comb begin
    op = op_x;
    case (idx)
      2'd1:    op = op_y;
      2'd2:    op = op_z;
      default: op = op_x;
    endcase
  end

  // A square is never negative, and even (-2^(IN_W-1))^2 fits in 2*IN_W signed bits,
  // so the product can be reinterpreted as unsigned without loss.
  assign prod    = op * op;
  assign prod_u  = $unsigned(prod);
  assign scaled  = acc >> SHIFT;
  assign sat_hit = (scaled > OUT_MAX);

  // Control FSM with datapath; all outputs registered.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sq_sum    <= '0;
      sq_sat    <= 1'b0;
      acc       <= '0;
      idx       <= 2'd0;
      op_x      <= '0;
      op_y      <= '0;
      op_z      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_x     <= vec_x;
            op_y     <= vec_y;
            op_z     <= vec_z;
            acc      <= '0;
            idx      <= 2'd0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= acc + {{(ACC_W-2*IN_W){1'b0}}, prod_u};
          if (idx == 2'd2) begin
            idx   <= 2'd0;
            state <= SAT;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        SAT: begin
          sq_sum    <= sat_hit ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
          sq_sat    <= sat_hit;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_of_squares_fx.sv
// Scoreboard bench for sum_of_squares_fx: driver pushes model results on accept,
// a monitor pops and compares on each output handshake.
module tb_sum_of_squares_fx;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] vec_x = '0, vec_y = '0, vec_z = '0;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sq_sum;
  logic        sq_sat;

  sum_of_squares_fx dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
    .vec_x(vec_x), .vec_y(vec_y), .vec_z(vec_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .sq_sum(sq_sum), .sq_sat(sq_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned sum;
    int unsigned sat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tot = 0;
  int   pass = 0;
  bit   bp_en = 1'b0;
  bit   or_force = 1'b1;
  bit   holding = 1'b0;
  int unsigned held_sum, held_sat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tot++;
    if (act == exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    tot++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: exact sum of squares of the real values, truncated to 4 fraction bits, clamped.
  function automatic exp_t model(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    exp_t e;
    int sx, sy, sz, s;
    sx = int'($signed(x)); sy = int'($signed(y)); sz = int'($signed(z));
    s = (sx*sx + sy*sy + sz*sz) / 16;
    if (s > 4095) begin e.sum = 4095; e.sat = 1; end
    else begin e.sum = s; e.sat = 0; end
    e.cyc = 0;
    return e;
  endfunction

  // out_ready owner: random backpressure or a forced level, changed just after each edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? ($urandom_range(0, 3) != 0) : or_force;
    end
  end

  // Monitor: latency on first sight, stability while held, values on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ && out_valid) begin
        if (!holding) begin
          holding = 1'b1;
          held_sum = int'(sq_sum);
          held_sat = int'(sq_sat);
          if (q.size() == 0) fail_now("spurious_out_valid");
          else chk("latency", cyc - q[0].cyc, 4);
        end else begin
          chk("hold_sum_stable", int'(sq_sum), held_sum);
          chk("hold_sat_stable", int'(sq_sat), held_sat);
        end
        if (out_ready && q.size() > 0) begin
          chk("sq_sum", int'(sq_sum), q[0].sum);
          chk("sq_sat", int'(sq_sat), q[0].sat);
          void'(q.pop_front());
          holding = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    exp_t e;
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; vec_x = x; vec_y = y; vec_z = z;
    while (!in_ready && w < 60) begin @(negedge clk); w++; end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e = model(x, y, z);
    e.cyc = cyc;
    q.push_back(e);
    // Scramble inputs after accept: the block must have sampled them already.
    in_valid = 1'b0;
    vec_x = 12'($urandom); vec_y = 12'($urandom); vec_z = 12'($urandom);
  endtask

  task automatic wait_out_valid(input string name);
    int w = 0;
    while (!out_valid && w < 30) begin @(negedge clk); w++; end
    if (!out_valid) fail_now(name);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_sq_sum"}, int'(sq_sum), 0);
    chk({tag, "_sq_sat"}, int'(sq_sat), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  logic [11:0] dir_x[10] = '{12'h010, 12'h030, 12'hFD0, 12'h0FF, 12'h7FF, 12'h800, 12'h093, 12'h800, 12'h000, 12'hFFF};
  logic [11:0] dir_y[10] = '{12'h000, 12'h040, 12'hFC0, 12'h000, 12'h000, 12'h000, 12'h093, 12'h800, 12'h000, 12'hFFF};
  logic [11:0] dir_z[10] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h093, 12'h800, 12'h000, 12'hFFF};

  initial begin
    int w;
    logic [11:0] rx, ry, rz;
    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_ = 1'b0;

    // Directed vectors, out_ready tied high.
    for (int i = 0; i < 10; i++) send(dir_x[i], dir_y[i], dir_z[i]);

    // Backpressure: hold result 10 cycles while a new vector waits.
    w = 0;
    while (q.size() > 0 && w < 50) begin @(negedge clk); w++; end
    or_force = 1'b0;
    @(posedge clk); #2;
    send(12'h030, 12'h040, 12'h000);
    wait_out_valid("bp_out_valid");
    in_valid = 1'b1; vec_x = 12'h0FF; vec_y = 12'h010; vec_z = 12'hF00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_out_valid_high", int'(out_valid), 1);
    end
    or_force = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_in_ready", int'(in_ready), 1);
    chk("post_hs_out_valid", int'(out_valid), 0);
    begin
      exp_t e;
      @(posedge clk); #1;
      e = model(12'h0FF, 12'h010, 12'hF00);
      e.cyc = cyc;
      q.push_back(e);
      in_valid = 1'b0;
    end
    w = 0;
    while (q.size() > 0 && w < 50) begin @(negedge clk); w++; end

    // Reset while accumulating.
    send(12'h7FF, 12'h123, 12'h456);
    @(posedge clk); #2;
    rst_ = 1'b1;
    #1;
    reset_checks("rst_acc");
    q.delete();
    holding = 1'b0;
    @(negedge clk); rst_ = 1'b0;
    send(12'h030, 12'h040, 12'h000);

    // Reset while holding a result: out_valid must fall with reset, not at an edge.
    w = 0;
    while (q.size() > 0 && w < 50) begin @(negedge clk); w++; end
    or_force = 1'b0;
    @(posedge clk); #2;
    send(12'h0FF, 12'h000, 12'h000);
    wait_out_valid("rst_hold_out_valid");
    @(posedge clk); #2;
    rst_ = 1'b1;
    #1;
    reset_checks("rst_hold");
    q.delete();
    holding = 1'b0;
    @(negedge clk); rst_ = 1'b0;
    or_force = 1'b1;
    send(12'hFD0, 12'hFC0, 12'h000);

    // Random vectors with random backpressure; magnitude mixed so both sides of saturation occur.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          rx = 12'($signed(7'($urandom))); ry = 12'($signed(7'($urandom))); rz = 12'($signed(7'($urandom)));
        end
        1: begin
          rx = 12'($signed(9'($urandom))); ry = 12'($signed(9'($urandom))); rz = 12'($signed(9'($urandom)));
        end
        default: begin
          rx = 12'($urandom); ry = 12'($urandom); rz = 12'($urandom);
        end
      endcase
      send(rx, ry, rz);
    end

    w = 0;
    while (q.size() > 0 && w < 300) begin @(negedge clk); w++; end
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
